// File: rtl/alu_taylor_calc.sv
// alu_taylor_calc: fixed-point sine/cosine by truncated Taylor series (Horner's rule).
// Every multiply goes to an external DSP48A1 slice over flat buses. Additions,
// shifts and saturation stay in fabric. One request is in flight at a time.
// Build option: define ALU_TAYLOR_ROUND_EN to round every product shift half-up
// instead of truncating. Latency does not depend on this option.
module alu_taylor_calc #(
  parameter int unsigned DSP_LATENCY = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               do_calc,
  input  logic [2:0]         function_sel,
  input  logic signed [17:0] x_in,
  output logic               calc_done,
  output logic signed [17:0] result,
  output logic [43:0]        dsp_ins_flat,
  input  logic [83:0]        dsp_outs_flat
);

  // Function codes shared with the rest of the ALU
  localparam logic [2:0] ALU_TAYLOR_SIN = 3'd0;
  localparam logic [2:0] ALU_TAYLOR_COS = 3'd1;

  localparam logic [7:0] OpMul  = 8'h01;
  localparam int unsigned CntW  = $clog2(DSP_LATENCY + 1) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DSP_LATENCY);

  typedef enum logic [2:0] {
    StIdle,
    StSq,
    StHorner,
    StFinal,
    StDone
  } state_e;

  // Clamp a wide signed value into the 18-bit result range
  function automatic logic signed [17:0] sat18(input logic signed [47:0] v);
    logic signed [17:0] r;
    if (v > 48'sd131071) begin
      r = 18'sh1ffff;
    end else if (v < -48'sd131072) begin
      r = 18'sh20000;
    end else begin
      r = v[17:0];
    end
    return r;
  endfunction

  // Arithmetic right shift of a product, optionally rounded half-up, then saturated
  function automatic logic signed [17:0] sat_shift(input logic signed [47:0] p,
                                                   input int unsigned sh);
    logic signed [47:0] v;
    v = p >>> sh;
`ifdef ALU_TAYLOR_ROUND_EN
    v = v + ((p >>> (sh - 1)) & 48'sd1);
`else
    v = v + 48'sd0;
`endif
    return sat18(v);
  endfunction

  function automatic logic signed [47:0] sext48(input logic signed [17:0] a);
    return $signed({{30{a[17]}}, a});
  endfunction

  // Coefficients in Q1.16, index 0 is the highest-order term
  function automatic logic signed [17:0] coef(input logic is_cos, input logic [2:0] idx);
    logic signed [17:0] c;
    if (is_cos) begin
      case (idx)
        3'd0:    c = 18'sd2;
        3'd1:    c = -18'sd91;
        3'd2:    c = 18'sd2731;
        3'd3:    c = -18'sd32768;
        default: c = 18'sd65536;
      endcase
    end else begin
      case (idx)
        3'd0:    c = -18'sd13;
        3'd1:    c = 18'sd546;
        3'd2:    c = -18'sd10923;
        default: c = 18'sd65536;
      endcase
    end
    return c;
  endfunction

  function automatic logic [43:0] issue(input logic signed [17:0] a,
                                        input logic signed [17:0] b);
    return {OpMul, a, b};
  endfunction

  state_e             r_state, w_state_nxt;
  logic signed [17:0] r_x, w_x_nxt;
  logic               r_is_cos, w_is_cos_nxt;
  logic signed [17:0] r_x2, w_x2_nxt;
  logic signed [17:0] r_acc, w_acc_nxt;
  logic [2:0]         r_step, w_step_nxt;
  logic [CntW-1:0]    r_cnt, w_cnt_nxt;
  logic [43:0]        r_dsp_ins, w_dsp_ins_nxt;
  logic               r_calc_done, w_calc_done_nxt;
  logic signed [17:0] r_result, w_result_nxt;

  logic signed [47:0] w_p;
  logic               w_mul_done;
  logic [2:0]         w_last_step;
  logic signed [17:0] w_x2_new;
  logic signed [17:0] w_acc_new;
  logic signed [17:0] w_fin;
  logic signed [17:0] w_top;
  logic               w_unused_m;

  // The M port duplicates A*B, only P is consumed
  assign w_unused_m = ^dsp_outs_flat[83:48];

  assign w_p         = $signed(dsp_outs_flat[47:0]);
  assign w_mul_done  = (r_cnt == CntLast);
  assign w_last_step = r_is_cos ? 3'd4 : 3'd3;
  assign w_x2_new    = sat_shift(w_p, 17);
  assign w_acc_new   = sat18(sext48(coef(r_is_cos, r_step)) + sext48(sat_shift(w_p, 15)));
  assign w_fin       = sat_shift(w_p, 16);
  assign w_top       = coef(r_is_cos, 3'd0);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_x         <= '0;
      r_is_cos    <= 1'b0;
      r_x2        <= '0;
      r_acc       <= '0;
      r_step      <= '0;
      r_cnt       <= '0;
      r_dsp_ins   <= '0;
      r_calc_done <= 1'b0;
      r_result    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_is_cos    <= w_is_cos_nxt;
      r_x2        <= w_x2_nxt;
      r_acc       <= w_acc_nxt;
      r_step      <= w_step_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dsp_ins   <= w_dsp_ins_nxt;
      r_calc_done <= w_calc_done_nxt;
      r_result    <= w_result_nxt;
    end
  end

  // Next-state: each multiply is issued on the edge that captures the previous product,
  // so the DSP inputs stay frozen for the whole wait.
  always_comb begin
    w_state_nxt     = r_state;
    w_x_nxt         = r_x;
    w_is_cos_nxt    = r_is_cos;
    w_x2_nxt        = r_x2;
    w_acc_nxt       = r_acc;
    w_step_nxt      = r_step;
    w_cnt_nxt       = r_cnt;
    w_dsp_ins_nxt   = r_dsp_ins;
    w_calc_done_nxt = 1'b0;
    w_result_nxt    = r_result;

    case (r_state)
      StIdle: begin
        w_dsp_ins_nxt = '0;
        w_cnt_nxt     = '0;
        if (do_calc) begin
          w_x_nxt      = x_in;
          w_is_cos_nxt = (function_sel == ALU_TAYLOR_COS);
          if (function_sel == ALU_TAYLOR_SIN || function_sel == ALU_TAYLOR_COS) begin
            w_dsp_ins_nxt = issue(x_in, x_in);
            w_state_nxt   = StSq;
          end else begin
            w_acc_nxt   = '0;
            w_state_nxt = StDone;
          end
        end
      end

      StSq: begin
        if (w_mul_done) begin
          w_x2_nxt      = w_x2_new;
          w_acc_nxt     = w_top;
          w_step_nxt    = 3'd1;
          w_cnt_nxt     = '0;
          w_dsp_ins_nxt = issue(w_top, w_x2_new);
          w_state_nxt   = StHorner;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end

      StHorner: begin
        if (w_mul_done) begin
          w_acc_nxt = w_acc_new;
          w_cnt_nxt = '0;
          if (r_step == w_last_step) begin
            if (r_is_cos) begin
              w_dsp_ins_nxt = '0;
              w_state_nxt   = StDone;
            end else begin
              w_dsp_ins_nxt = issue(w_acc_new, r_x);
              w_state_nxt   = StFinal;
            end
          end else begin
            w_step_nxt    = r_step + 3'd1;
            w_dsp_ins_nxt = issue(w_acc_new, r_x2);
          end
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end

      StFinal: begin
        if (w_mul_done) begin
          w_acc_nxt     = w_fin;
          w_cnt_nxt     = '0;
          w_dsp_ins_nxt = '0;
          w_state_nxt   = StDone;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end

      StDone: begin
        w_calc_done_nxt = 1'b1;
        w_result_nxt    = r_acc;
        w_dsp_ins_nxt   = '0;
        w_state_nxt     = StIdle;
      end

      default: begin
        w_dsp_ins_nxt = '0;
        w_state_nxt   = StIdle;
      end
    endcase
  end

  assign calc_done    = r_calc_done;
  assign result       = r_result;
  assign dsp_ins_flat = r_dsp_ins;

endmodule

// File: tb/tb_alu_taylor_calc.sv
// Testbench for alu_taylor_calc: behavioural DSP48A1 stand-in, directed cases at
// 0 and +-pi/2, busy-strobe and reset-abort cases, and randomized arguments
// compared against an integer reference of the Taylor evaluation.
module tb_alu_taylor_calc;

  localparam int DspLat = 3;
  localparam int ExpLat = 5 * (DspLat + 1) + 1;
  localparam logic signed [17:0] HalfPi = 18'sh19220;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               do_calc = 1'b0;
  logic [2:0]         function_sel = 3'd0;
  logic signed [17:0] x_in = '0;
  logic               calc_done;
  logic signed [17:0] result;
  logic [43:0]        dsp_ins_flat;
  logic [83:0]        dsp_outs_flat;

  int n_tests = 0;
  int n_fail  = 0;

  alu_taylor_calc #(
    .DSP_LATENCY(DspLat)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .do_calc      (do_calc),
    .function_sel (function_sel),
    .x_in         (x_in),
    .calc_done    (calc_done),
    .result       (result),
    .dsp_ins_flat (dsp_ins_flat),
    .dsp_outs_flat(dsp_outs_flat)
  );

  always #5 clk = ~clk;

  // DSP48A1 stand-in: product of the inputs appears DspLat edges after they are driven
  logic [47:0] dsp_pipe [DspLat];
  logic signed [47:0] dsp_prod;
  always_comb begin
    dsp_prod = '0;
    if (dsp_ins_flat[43:36] == 8'h01) begin
      dsp_prod = 48'($signed(dsp_ins_flat[35:18])) * 48'($signed(dsp_ins_flat[17:0]));
    end
  end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DspLat; i++) dsp_pipe[i] <= '0;
    end else begin
      dsp_pipe[0] <= dsp_prod;
      for (int i = 1; i < DspLat; i++) dsp_pipe[i] <= dsp_pipe[i-1];
    end
  end
  assign dsp_outs_flat = {dsp_pipe[DspLat-1][35:0], dsp_pipe[DspLat-1]};

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint m_sat(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  function automatic longint m_shr(input longint v, input int s);
    longint r;
    r = v >>> s;
`ifdef ALU_TAYLOR_ROUND_EN
    r = r + ((v >>> (s - 1)) & 64'sd1);
`endif
    return r;
  endfunction

  function automatic longint ref_calc(input int sel, input longint x);
    longint c[$];
    longint x2, acc;
    if (sel == 0) c = '{-13, 546, -10923, 65536};
    else if (sel == 1) c = '{2, -91, 2731, -32768, 65536};
    else return 0;
    x2  = m_sat(m_shr(x * x, 17));
    acc = c[0];
    for (int k = 1; k < c.size(); k++) acc = m_sat(c[k] + m_sat(m_shr(acc * x2, 15)));
    if (sel == 0) acc = m_sat(m_shr(acc * x, 16));
    return acc;
  endfunction

  function automatic bit near(input longint v, input longint target);
    // The 7th/8th-order truncated series lands up to ~26 LSB off at +-pi/2
    return (v - target <= 32) && (target - v <= 32);
  endfunction

  // Issue one request; lat is edges from the accepting edge to calc_done, -1 on timeout
  task automatic run_calc(input logic [2:0] sel, input logic signed [17:0] x, input bit inject,
                          output logic signed [17:0] res, output int lat);
    @(negedge clk);
    function_sel = sel;
    x_in         = x;
    do_calc      = 1'b1;
    @(posedge clk);
    #1;
    do_calc = 1'b0;
    lat     = -1;
    res     = '0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (inject && i == 8) begin
        do_calc      = 1'b1;
        function_sel = (sel == 3'd0) ? 3'd1 : 3'd0;
        x_in         = 18'sh0abcd;
      end else begin
        do_calc = 1'b0;
      end
      if (calc_done) begin
        lat = i;
        res = result;
        break;
      end
    end
    do_calc = 1'b0;
  endtask

  logic signed [17:0] res, first_sin, first_cos;
  int lat, seen;

  initial begin
    // Reset held 100 cycles
    repeat (100) @(posedge clk);
    #1;
    check_val("rst_calc_done", calc_done, 0);
    check_val("rst_result", result, 0);
    check_val("rst_dsp_ins", dsp_ins_flat, 0);
    reset = 1'b0;

    // Idle after release: no completion
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (calc_done) seen++;
    end
    check_val("idle_no_done", seen, 0);

    // pi/2
    run_calc(3'd0, HalfPi, 1'b0, res, lat);
    check_val("sin_pi2_lat", lat, ExpLat);
    check_val("sin_pi2_model", res, ref_calc(0, HalfPi));
    check_val("sin_pi2_near", near(res, 65536), 1);
    check_val("idle_opmode", dsp_ins_flat, 0);
    repeat (5) @(posedge clk);
    #1;
    check_val("result_held", result, res);

    run_calc(3'd1, HalfPi, 1'b0, res, lat);
    check_val("cos_pi2_lat", lat, ExpLat);
    check_val("cos_pi2_model", res, ref_calc(1, HalfPi));
    check_val("cos_pi2_near", near(res, 0), 1);

    // Zero and -pi/2
    run_calc(3'd0, 18'sd0, 1'b0, res, lat);
    check_val("sin_0_model", res, ref_calc(0, 0));
    check_val("sin_0_near", near(res, 0), 1);
    run_calc(3'd1, 18'sd0, 1'b0, res, lat);
    check_val("cos_0_model", res, ref_calc(1, 0));
    check_val("cos_0_near", near(res, 65536), 1);
    run_calc(3'd0, -HalfPi, 1'b0, res, lat);
    check_val("sin_m_pi2_model", res, ref_calc(0, -HalfPi));
    check_val("sin_m_pi2_near", near(res, -65536), 1);
    run_calc(3'd1, -HalfPi, 1'b0, res, lat);
    check_val("cos_m_pi2_model", res, ref_calc(1, -HalfPi));
    check_val("cos_m_pi2_near", near(res, 0), 1);

    // Alternate SIN/COS with a stray strobe mid-calculation
    first_sin = 18'(ref_calc(0, HalfPi));
    first_cos = 18'(ref_calc(1, HalfPi));
    for (int it = 0; it < 10; it++) begin
      run_calc(3'd0, HalfPi, 1'b1, res, lat);
      check_val("alt_sin_lat", lat, ExpLat);
      check_val("alt_sin_res", res, first_sin);
      repeat (100) @(posedge clk);
      run_calc(3'd1, HalfPi, 1'b1, res, lat);
      check_val("alt_cos_lat", lat, ExpLat);
      check_val("alt_cos_res", res, first_cos);
      repeat (100) @(posedge clk);
    end

    // Reset 10 cycles into a calculation aborts it
    @(negedge clk);
    function_sel = 3'd0;
    x_in         = HalfPi;
    do_calc      = 1'b1;
    @(posedge clk);
    #1;
    do_calc = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    seen  = 0;
    for (int i = 0; i < 43; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) reset = 1'b0;
      if (calc_done) seen++;
    end
    check_val("abort_no_done", seen, 0);
    check_val("abort_result", result, 0);
    run_calc(3'd1, HalfPi, 1'b0, res, lat);
    check_val("post_abort_lat", lat, ExpLat);
    check_val("post_abort_res", res, ref_calc(1, HalfPi));

    // Unsupported function code
    run_calc(3'd5, HalfPi, 1'b0, res, lat);
    check_val("bad_sel_lat", lat, 1);
    check_val("bad_sel_res", res, 0);

    // Randomized arguments and codes
    for (int it = 0; it < 40; it++) begin
      int sel;
      logic signed [17:0] x;
      sel = (it % 8 == 7) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, 1));
      if (it % 2 == 0) x = 18'($signed($urandom_range(0, 2 * 18'h19220)) - 32'sh19220);
      else x = 18'($urandom);
      run_calc(3'(sel), x, 1'b0, res, lat);
      check_val("rand_lat", lat, (sel <= 1) ? ExpLat : 1);
      check_val("rand_res", res, ref_calc(sel, x));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
